// File: rtl/window_slider.sv
// Slides the menu box between its off-screen park row and a target row,
// updating position and visibility once per frame at the blanking line.
module window_slider #(
  parameter int unsigned VBLANK_LINE = 768,
  parameter int unsigned HIDDEN_Y    = 768,
  parameter int unsigned STEP        = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [9:0]  vcount_in,
  input  logic        open_in,
  input  logic        close_in,
  input  logic [10:0] x_target_in,
  input  logic [9:0]  y_target_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        visible_out,
  output logic        busy_out,
  output logic        done_out
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned CW = 11;

  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} state_t;

  state_t        state, state_nxt;
  logic          prev_match, line_match, tick;
  logic          pend_open, pend_close, pend_open_nxt, pend_close_nxt;
  logic          clr_open, clr_close;
  logic [XW-1:0] tx, x_nxt;
  logic [YW-1:0] ty, y_nxt;
  logic          vis_nxt, done_nxt;
  logic [CW-1:0] y_ext, ty_ext;
  logic          open_done, close_done;

  // One tick on the first cycle vcount sits on the blanking line.
  assign line_match = (vcount_in == YW'(VBLANK_LINE));
  assign tick       = line_match & ~prev_match;

  // Widened so ty + STEP and y + STEP cannot wrap.
  assign y_ext      = CW'(y_out);
  assign ty_ext     = CW'(ty);
  assign open_done  = (y_ext <= ty_ext + CW'(STEP));
  assign close_done = (y_ext + CW'(STEP) >= CW'(HIDDEN_Y));

  assign busy_out = (state == OPENING) || (state == CLOSING);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= CLOSED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_open  = 1'b0;
    clr_close = 1'b0;
    if (tick) begin
      case (state)
        CLOSED: begin
          clr_open  = 1'b1;
          clr_close = 1'b1;
          if (pend_open) state_nxt = OPENING;
        end
        OPENING: if (open_done) state_nxt = OPEN;
        OPEN: begin
          clr_open  = 1'b1;
          clr_close = 1'b1;
          if (pend_close) state_nxt = CLOSING;
        end
        CLOSING: if (close_done) state_nxt = CLOSED;
        default: state_nxt = CLOSED;
      endcase
    end
  end

  always_comb begin
    x_nxt    = x_out;
    y_nxt    = y_out;
    vis_nxt  = visible_out;
    done_nxt = 1'b0;
    if (tick) begin
      case (state)
        CLOSED: begin
          if (pend_open) begin
            x_nxt   = tx;
            vis_nxt = 1'b1;
          end
        end
        OPENING: begin
          if (open_done) begin
            y_nxt    = ty;
            done_nxt = 1'b1;
          end else begin
            y_nxt = y_out - YW'(STEP);
          end
        end
        CLOSING: begin
          if (close_done) begin
            y_nxt    = YW'(HIDDEN_Y);
            vis_nxt  = 1'b0;
            done_nxt = 1'b1;
          end else begin
            y_nxt = y_out + YW'(STEP);
          end
        end
        default: ;
      endcase
    end
  end

  // A new request lands after the tick's clears, so it survives to the next frame.
  always_comb begin
    pend_open_nxt  = pend_open & ~clr_open;
    pend_close_nxt = pend_close & ~clr_close;
    if (open_in && !close_in) begin
      pend_open_nxt  = 1'b1;
      pend_close_nxt = 1'b0;
    end else if (close_in && !open_in) begin
      pend_open_nxt  = 1'b0;
      pend_close_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_match  <= 1'b0;
      pend_open   <= 1'b0;
      pend_close  <= 1'b0;
      tx          <= '0;
      ty          <= '0;
      x_out       <= '0;
      y_out       <= YW'(HIDDEN_Y);
      visible_out <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      prev_match  <= line_match;
      pend_open   <= pend_open_nxt;
      pend_close  <= pend_close_nxt;
      if (open_in && !close_in) begin
        tx <= x_target_in;
        ty <= y_target_in;
      end
      x_out       <= x_nxt;
      y_out       <= y_nxt;
      visible_out <= vis_nxt;
      done_out    <= done_nxt;
    end
  end

endmodule

// File: doc/window_slider.md
# window_slider

Animation controller for the on-screen text/menu box rectangle generator. It accepts open and close requests from game logic and slides the box vertically between an off-screen park row and a requested target position. It drives the generator's position inputs and a visibility gate. All position and visibility changes occur once per frame at a fixed vertical-blanking line, so the box never tears mid-frame.

## Interface
- VBLANK_LINE, 768: vcount value that marks the per-frame update point (first blanking line).
- HIDDEN_Y, 768: park row. `y_out` sits here whenever the box is closed.
- STEP, 8: pixels moved per frame during an animation; must be ≥1.

Ports:
- clk_in  in  1  pixel clock, the same domain as hcount/vcount.
- rst_in  in  1  synchronous, active-high reset.
- vcount_in  in  10  current video line.
- open_in  in  1  single-cycle open request.
- close_in  in  1  single-cycle close request.
- x_target_in  in  11  box x position; sampled only when an open request is latched.
- y_target_in  in  10  box final y position; sampled only when an open request is latched.
- x_out  out  11  x position fed to the rectangle generator.
- y_out  out  10  y position fed to the rectangle generator.
- visible_out  out  1  gates the generator's pixel output.
- busy_out  out  1  high while an animation is in progress.
- done_out  out  1  one-cycle pulse when an open or close animation completes.

## Operation
- Frame tick: `line_match = (vcount_in == VBLANK_LINE)`, with a registered copy `prev_match`; `tick = line_match & ~prev_match`.
  - Exactly one tick per frame, however long vcount is held at VBLANK_LINE.
- Pending requests:
  - `open_in` alone: sets `pend_open`, clears `pend_close`, and latches `x_target_in`/`y_target_in` into the target registers.
  - `close_in` alone: sets `pend_close`, clears `pend_open`.
  - Both in the same cycle: both are ignored; pending flags and targets are unchanged.
  - The latest request wins.
- States: CLOSED, OPENING, OPEN, CLOSING. They are evaluated only on tick cycles; between ticks, state and outputs hold.
- CLOSED:
  - `pend_open`: `x_out` ← target x, `visible_out` ← 1, `y_out` stays HIDDEN_Y, clear `pend_open`, go to OPENING.
  - `pend_close`: cleared, no-op.
- OPENING:
  - If `y_out ≤ ty + STEP` (compared at 11 bits, no overflow): `y_out` ← ty, `done_out` pulses, go to OPEN.
  - Otherwise `y_out` ← `y_out − STEP`.
  - Pending flags are untouched.
- OPEN:
  - `pend_close`: clear it, go to CLOSING; `y_out` is unchanged on this tick.
  - `pend_open`: cleared, no-op (a new target is not applied).
- CLOSING:
  - If `y_out + STEP ≥ HIDDEN_Y`: `y_out` ← HIDDEN_Y, `visible_out` ← 0, `done_out` pulses, go to CLOSED.
  - Otherwise `y_out` ← `y_out + STEP`.
  - Pending flags are untouched.
- Consequences:
  - A close requested during OPENING is honored on the first tick after OPEN is reached.
  - An open requested during CLOSING is honored on the first tick after CLOSED is reached.
- A target with ty ≥ HIDDEN_Y is legal: the open completes on the first OPENING tick with `y_out` = ty.
- `busy_out` = (state is OPENING or CLOSING); it is decoded from the registered state.

## Timing
- Reset values:
  - `x_out` = 0, `y_out` = HIDDEN_Y, `visible_out` = 0, `busy_out` = 0, `done_out` = 0.
  - State = CLOSED, pending flags = 0, targets = 0, `prev_match` = 0.
- Reset mid-animation: all of the above take effect on the next clock edge, and any pending request is lost.
- All outputs are registered and change on the clock edge where `tick` is true.
- A request arriving in the same cycle as a tick is not consumed by that tick; it is consumed at the next frame's tick.
- Open latency:
  - Request → visible: next tick.
  - Visible → done: ceil((HIDDEN_Y − ty)/STEP) further ticks.
- Close latency: 1 tick to leave OPEN, then ceil((HIDDEN_Y − ty)/STEP) ticks; `visible_out` falls on the completing tick.
- `done_out` is high for exactly one `clk_in` cycle.

## Test plan
- Reset: hold `rst_in` 2 cycles → `y_out` = 768, `x_out` = 0, `visible_out`/`busy_out`/`done_out` = 0. Then hold vcount = 768 for 500 cycles → exactly one tick, no output change.
- Open: tx = 100, ty = 700, pulse `open_in` →
  - tick 1: `x_out` = 100, `visible_out` = 1, `busy_out` = 1, `y_out` = 768;
  - ticks 2–10: `y_out` = 760, 752, …, 704, 700;
  - `done_out` pulses once on tick 10, then `busy_out` = 0.
- Close during opening: same open, pulse `close_in` at tick 4 → OPEN reached at tick 10, CLOSING entered at tick 11, `y_out` = 708 … 764, 768 with `visible_out` = 0 and `done_out` on tick 20.
- Request filtering:
  - `open_in` and `close_in` in the same cycle while CLOSED → no change for 3 frames.
  - `open_in` while OPEN with a new target → position unchanged.
- Reset mid-CLOSING at `y_out` = 740 → next edge: `y_out` = 768, `visible_out` = 0, state CLOSED; an `open_in` pending before reset is not honored.
- ty = 780 (≥ HIDDEN_Y): open → tick 1 visible, tick 2 `y_out` = 780 with `done_out`.
